seg7_reader: RTL and testbench
==============================

# seg7_reader

Recovers BCD digits from a multiplexed, active-low seven-segment bus. It is the decoding counterpart of the BCD-to-segment display driver and is used to read back and self-check the display path. The block samples the segment and digit-select lines, requires each pattern to stay stable for a set number of cycles, and decodes it to a 4-bit digit. It stores one digit per display position and reports every change through a valid/ready event port.

## Interface
- NUM_DIGITS, 4: number of multiplexed display positions (1..8).
- STABLE_CYCLES, 4: consecutive identical samples required before commit (2..255).
- clk  in  1  sole clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- seg_n  in  7  segment lines, active-low; bit6=a … bit0=g.
- dig_en_n  in  NUM_DIGITS  digit selects, active-low; exactly one low selects a position.
- digits_out  out  4*NUM_DIGITS  stored BCD per position; position i at [4i+3:4i].
- digit_valid  out  NUM_DIGITS  position has received at least one legal pattern.
- bad_pattern  out  NUM_DIGITS  last commit on position was an illegal pattern.
- evt_valid  out  1  change event pending.
- evt_ready  in  1  consumer accepts event.
- evt_idx  out  3  position of pending event.
- evt_digit  out  4  decoded value of pending event (0 if evt_bad).
- evt_bad  out  1  pending event is an illegal pattern.
- evt_overflow  out  1  sticky: an event was dropped.

## Operation
- Legal patterns (after inversion, a..g): 1111110=0, 0110000=1, 1101101=2, 1111001=3, 0110011=4, 1011011=5, 1011111=6, 1110000=7, 1111111=8, 1111011=9. Every other pattern is illegal.
- Input register captures {seg_n, dig_en_n} on each edge. The stability counter is saturating and 8 bits wide.
  - Captured value equal to the previous capture: counter increments.
  - Otherwise: counter loads 1.
- FSM states:
  - IDLE: dig_en_n is not one-hot-low (none selected or more than one selected). No commit.
  - QUALIFY: counting toward STABLE_CYCLES.
  - LOCKED: committed. No further commit until the input changes.
- FSM transitions:
  - Any change to the captured value: go to QUALIFY if dig_en_n is one-hot-low, else go to IDLE.
  - QUALIFY with counter == STABLE_CYCLES: commit, go to LOCKED.
- Commit of a legal pattern at position i:
  - digits_out[i] <= value, digit_valid[i] <= 1, bad_pattern[i] <= 0.
- Commit of an illegal pattern at position i:
  - bad_pattern[i] <= 1; digits_out[i] and digit_valid[i] are unchanged.
- Event generation: an event is generated only when a commit changes digits_out[i], digit_valid[i] or bad_pattern[i]. Re-committing an identical pattern generates no event.
- Event port: single entry.
  - Event generated while evt_valid=0: it is loaded.
  - Event generated while evt_valid=1 and no handshake in the same cycle: the new event is dropped, evt_overflow <= 1, and the pending event is held.
  - Handshake and a new event in the same cycle: the new event is loaded and no overflow is flagged.
- Event fields are stable while evt_valid=1 && evt_ready=0.
- evt_overflow clears only on reset.

## Timing
- Reset values: digits_out=0, digit_valid=0, bad_pattern=0, evt_valid=0, evt_idx=0, evt_digit=0, evt_bad=0, evt_overflow=0, FSM=IDLE, counter=0, input register = all ones (nothing selected).
- Commit latency: let E be the first edge that captures a new value which then stays constant.
  - The counter reaches STABLE_CYCLES at edge E+STABLE_CYCLES-1.
  - Storage outputs and evt_valid are registered at edge E+STABLE_CYCLES.
- A glitch lasting fewer than STABLE_CYCLES samples never commits. Returning to the prior value restarts the count from 1.
- Event transfer occurs on any edge with evt_valid && evt_ready. If no new event loads in that cycle, evt_valid drops on that edge.
- Reset asserted mid-operation: all state clears immediately (asynchronous assertion). The pending event is lost. Qualification restarts after release.

## Structure
- Shared package seg7_pkg:
  - 7-bit segment constants SEG_0..SEG_9 (active-high form), shared with the display driver.
  - Function seg7_to_bcd returning {legal, value[3:0]}.
  - FSM state enum {IDLE, QUALIFY, LOCKED}.
- One sub-module, seg7_stabilizer: input register, change detect, saturating counter, and FSM. It outputs a one-cycle commit strobe with index and pattern.
- The top level holds the digit storage array and the event register.

## Test plan
- Stable input: seg_n=~7'b1111001, dig_en_n=4'b1101 held 10 cycles. Required: digits_out[7:4]=3 and digit_valid[1]=1 at E+4; exactly one event {idx=1, digit=3, bad=0}.
- Glitch rejection: pattern 8 on position 0 held 3 cycles, then pattern 5 held 6 cycles. Required: only 5 commits; exactly one event.
- Illegal pattern: seg_n=~7'b0000001 on position 2 after digit 7 was stored there. Required: bad_pattern[2]=1, digits_out[11:8] remains 7, event has evt_bad=1.
- Overflow: evt_ready=0 while commits on positions 0 and 3 occur. Required: pending event is position 0, evt_overflow=1. Raising evt_ready drains the event and evt_overflow remains 1.
- Multi-select: dig_en_n=4'b1100 held 20 cycles. Required: no commit and no event. Then dig_en_n=4'b1110 produces a commit at E+4.
- Mid-qualify reset: assert rst_n=0 at counter=2. Required: all outputs return to reset values in the same cycle. After release, the stable input commits STABLE_CYCLES edges after the first capture.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-high segment codes (a..g = bit6..bit0),
// pattern-to-BCD decode, stabilizer FSM states and the event payload.
package seg7_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned BCD_W = 4;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned CNT_W = 8;

  localparam logic [SEG_W-1:0] SEG_0 = 7'b1111110;
  localparam logic [SEG_W-1:0] SEG_1 = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_2 = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_3 = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_4 = 7'b0110011;
  localparam logic [SEG_W-1:0] SEG_5 = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_6 = 7'b1011111;
  localparam logic [SEG_W-1:0] SEG_7 = 7'b1110000;
  localparam logic [SEG_W-1:0] SEG_8 = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9 = 7'b1111011;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUALIFY = 2'd1,
    LOCKED  = 2'd2
  } stab_state_e;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [BCD_W-1:0] digit;
    logic             bad;
  } evt_t;

  // Returns {legal, value}; value is 0 for illegal patterns.
  function automatic logic [BCD_W:0] seg7_to_bcd(input logic [SEG_W-1:0] seg);
    logic [BCD_W:0] res;
    res = '0;
    case (seg)
      SEG_0:   res = {1'b1, 4'd0};
      SEG_1:   res = {1'b1, 4'd1};
      SEG_2:   res = {1'b1, 4'd2};
      SEG_3:   res = {1'b1, 4'd3};
      SEG_4:   res = {1'b1, 4'd4};
      SEG_5:   res = {1'b1, 4'd5};
      SEG_6:   res = {1'b1, 4'd6};
      SEG_7:   res = {1'b1, 4'd7};
      SEG_8:   res = {1'b1, 4'd8};
      SEG_9:   res = {1'b1, 4'd9};
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/seg7_stabilizer.sv
// Samples the segment/select bus, qualifies a pattern after STABLE_CYCLES identical
// captures and emits a one-cycle commit strobe with position and active-high pattern.
module seg7_stabilizer
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SEG_W-1:0]      seg_n_i,
  input  logic [NUM_DIGITS-1:0] dig_en_n_i,
  output logic                  commit_c_o,
  output logic [IDX_W-1:0]      idx_c_o,
  output logic [SEG_W-1:0]      seg_c_o
);

  localparam int unsigned IN_W = SEG_W + NUM_DIGITS;

  logic [IN_W-1:0]  in_q, in_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  stab_state_e      state_q, state_d;
  logic [NUM_DIGITS-1:0] en_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q    <= '1;
      cnt_q   <= '0;
      state_q <= IDLE;
    end else begin
      in_q    <= in_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  // A change restarts qualification; otherwise count (saturating) and lock on reaching the target.
  always_comb begin
    in_d    = {seg_n_i, dig_en_n_i};
    cnt_d   = cnt_q;
    state_d = state_q;
    if (in_d != in_q) begin
      cnt_d   = CNT_W'(1);
      state_d = $onehot(~dig_en_n_i) ? QUALIFY : IDLE;
    end else begin
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (state_q == QUALIFY && cnt_q == CNT_W'(STABLE_CYCLES)) begin
        state_d = LOCKED;
      end
    end
  end

  assign en_q       = in_q[NUM_DIGITS-1:0];
  assign seg_c_o    = ~in_q[IN_W-1 -: SEG_W];
  assign commit_c_o = (state_q == QUALIFY) && (cnt_q == CNT_W'(STABLE_CYCLES));

  always_comb begin
    idx_c_o = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (!en_q[i]) idx_c_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/seg7_reader.sv
// Seven-segment read-back: per-position digit storage fed by the stabilizer commits,
// plus a single-entry change-event register with sticky overflow.
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [SEG_W-1:0]          seg_n,
  input  logic [NUM_DIGITS-1:0]     dig_en_n,
  output logic [BCD_W*NUM_DIGITS-1:0] digits_out,
  output logic [NUM_DIGITS-1:0]     digit_valid,
  output logic [NUM_DIGITS-1:0]     bad_pattern,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [IDX_W-1:0]          evt_idx,
  output logic [BCD_W-1:0]          evt_digit,
  output logic                      evt_bad,
  output logic                      evt_overflow
);

  logic             commit_c;
  logic [IDX_W-1:0] idx_c;
  logic [SEG_W-1:0] seg_c;

  logic [BCD_W-1:0]      dig_q [NUM_DIGITS];
  logic [BCD_W-1:0]      dig_d [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] valid_q, valid_d, bad_q, bad_d;
  evt_t                  evt_q, evt_d, new_evt;
  logic                  evt_valid_q, evt_valid_d, ovf_q, ovf_d;
  logic [BCD_W:0]        dec;
  logic                  changed, hs;

  seg7_stabilizer #(
    .NUM_DIGITS   (NUM_DIGITS),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_stab (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_n_i   (seg_n),
    .dig_en_n_i(dig_en_n),
    .commit_c_o(commit_c),
    .idx_c_o   (idx_c),
    .seg_c_o   (seg_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) dig_q[i] <= '0;
      valid_q     <= '0;
      bad_q       <= '0;
      evt_q       <= '0;
      evt_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      dig_q       <= dig_d;
      valid_q     <= valid_d;
      bad_q       <= bad_d;
      evt_q       <= evt_d;
      evt_valid_q <= evt_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  // Storage update; an event is raised only when the commit alters stored state.
  always_comb begin
    dec           = seg7_to_bcd(seg_c);
    new_evt.idx   = idx_c;
    new_evt.digit = dec[BCD_W] ? dec[BCD_W-1:0] : '0;
    new_evt.bad   = ~dec[BCD_W];
    dig_d         = dig_q;
    valid_d       = valid_q;
    bad_d         = bad_q;
    changed       = 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (commit_c && idx_c == IDX_W'(i)) begin
        if (dec[BCD_W]) begin
          changed    = (dig_q[i] != dec[BCD_W-1:0]) || !valid_q[i] || bad_q[i];
          dig_d[i]   = dec[BCD_W-1:0];
          valid_d[i] = 1'b1;
          bad_d[i]   = 1'b0;
        end else begin
          changed  = !bad_q[i];
          bad_d[i] = 1'b1;
        end
      end
    end
  end

  // Single-entry event slot: a handshake frees the slot for a same-cycle event.
  always_comb begin
    hs          = evt_valid_q && evt_ready;
    evt_d       = evt_q;
    evt_valid_d = evt_valid_q;
    ovf_d       = ovf_q;
    if (changed && (!evt_valid_q || hs)) begin
      evt_d       = new_evt;
      evt_valid_d = 1'b1;
    end else if (changed) begin
      ovf_d = 1'b1;
    end else if (hs) begin
      evt_valid_d = 1'b0;
    end
  end

  for (genvar g = 0; g < int'(NUM_DIGITS); g++) begin : g_out
    assign digits_out[BCD_W*g +: BCD_W] = dig_q[g];
  end

  assign digit_valid  = valid_q;
  assign bad_pattern  = bad_q;
  assign evt_valid    = evt_valid_q;
  assign evt_idx      = evt_q.idx;
  assign evt_digit    = evt_q.digit;
  assign evt_bad      = evt_q.bad;
  assign evt_overflow = ovf_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Scenario bench for seg7_reader: expected events queued at stimulus time,
// popped and compared whenever the DUT hands an event over.
module tb_seg7_reader;
  import seg7_pkg::*;

  localparam int unsigned ND = 4;

  logic          clk, rst_n;
  logic [6:0]    seg_n;
  logic [ND-1:0] dig_en_n;
  logic [4*ND-1:0] digits_out;
  logic [ND-1:0] digit_valid, bad_pattern;
  logic          evt_valid, evt_ready, evt_bad, evt_overflow;
  logic [2:0]    evt_idx;
  logic [3:0]    evt_digit;

  int   errors   = 0;
  int   checks   = 0;
  int   evt_seen = 0;
  evt_t exp_q[$];
  evt_t exp_e;

  seg7_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .seg_n(seg_n), .dig_en_n(dig_en_n),
    .digits_out(digits_out), .digit_valid(digit_valid), .bad_pattern(bad_pattern),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_idx(evt_idx),
    .evt_digit(evt_digit), .evt_bad(evt_bad), .evt_overflow(evt_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every accepted event must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) begin
      evt_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL evt_unexpected: got idx=%0d digit=%0d bad=%0d, none expected",
                 evt_idx, evt_digit, evt_bad);
      end else begin
        exp_e = exp_q.pop_front();
        if ({evt_idx, evt_digit, evt_bad} !== exp_e) begin
          errors++;
          $display("FAIL evt_fields: got idx=%0d digit=%0d bad=%0d, expected idx=%0d digit=%0d bad=%0d",
                   evt_idx, evt_digit, evt_bad, exp_e.idx, exp_e.digit, exp_e.bad);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive(input logic [6:0] seg_hi, input logic [ND-1:0] en_n);
    seg_n    = ~seg_hi;
    dig_en_n = en_n;
  endtask

  task automatic expect_evt(input logic [2:0] idx, input logic [3:0] dig, input logic bad);
    evt_t e;
    e.idx = idx; e.digit = dig; e.bad = bad;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; evt_ready = 1'b1;
    drive(7'h00, '1);
    hold(2);
    checks++;
    if (digits_out !== '0 || digit_valid !== '0 || bad_pattern !== '0) begin
      errors++;
      $display("FAIL reset_storage: got digits=%h valid=%b bad=%b, expected 0", digits_out, digit_valid, bad_pattern);
    end
    checks++;
    if ({evt_valid, evt_idx, evt_digit, evt_bad, evt_overflow} !== '0) begin
      errors++;
      $display("FAIL reset_event: got v=%b idx=%0d d=%0d b=%b ovf=%b, expected 0",
               evt_valid, evt_idx, evt_digit, evt_bad, evt_overflow);
    end
    rst_n = 1'b1;
    hold(2);
  endtask

  task automatic test_stable();
    int seen0;
    seen0 = evt_seen;
    drive(SEG_3, 4'b1101);
    expect_evt(3'd1, 4'd3, 1'b0);
    hold(4);
    checks++;
    if (digit_valid[1] !== 1'b0) begin
      errors++;
      $display("FAIL stable_early: got valid[1]=%b at E+3, expected 0", digit_valid[1]);
    end
    tick();
    checks++;
    if (digits_out[7:4] !== 4'd3 || digit_valid[1] !== 1'b1) begin
      errors++;
      $display("FAIL stable_commit: got digit=%0d valid=%b at E+4, expected 3/1", digits_out[7:4], digit_valid[1]);
    end
    hold(6);
    checks++;
    if (evt_seen - seen0 != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stable_events: got %0d events, %0d pending, expected 1/0", evt_seen - seen0, exp_q.size());
    end
  endtask

  task automatic test_glitch();
    int seen0;
    seen0 = evt_seen;
    drive(SEG_8, 4'b1110);
    hold(3);
    drive(SEG_5, 4'b1110);
    expect_evt(3'd0, 4'd5, 1'b0);
    checks++;
    if (digit_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL glitch_commit: got valid[0]=%b after 3-sample glitch, expected 0", digit_valid[0]);
    end
    hold(6);
    checks++;
    if (digits_out[3:0] !== 4'd5 || digit_valid[0] !== 1'b1) begin
      errors++;
      $display("FAIL glitch_value: got digit=%0d valid=%b, expected 5/1", digits_out[3:0], digit_valid[0]);
    end
    hold(3);
    checks++;
    if (evt_seen - seen0 != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL glitch_events: got %0d events, %0d pending, expected 1/0", evt_seen - seen0, exp_q.size());
    end
  endtask

  task automatic test_illegal();
    drive(SEG_7, 4'b1011);
    expect_evt(3'd2, 4'd7, 1'b0);
    hold(8);
    drive(7'b0000001, 4'b1011);
    expect_evt(3'd2, 4'd0, 1'b1);
    hold(8);
    checks++;
    if (bad_pattern[2] !== 1'b1 || digits_out[11:8] !== 4'd7 || digit_valid[2] !== 1'b1) begin
      errors++;
      $display("FAIL illegal_store: got bad=%b digit=%0d valid=%b, expected 1/7/1",
               bad_pattern[2], digits_out[11:8], digit_valid[2]);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL illegal_events: got %0d pending, expected 0", exp_q.size());
    end
  endtask

  task automatic test_overflow();
    evt_ready = 1'b0;
    drive(SEG_1, 4'b1110);
    expect_evt(3'd0, 4'd1, 1'b0);
    hold(6);
    drive(SEG_9, 4'b0111);
    hold(6);
    checks++;
    if (evt_valid !== 1'b1 || evt_idx !== 3'd0 || evt_digit !== 4'd1 || evt_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_pending: got v=%b idx=%0d d=%0d ovf=%b, expected 1/0/1/1",
               evt_valid, evt_idx, evt_digit, evt_overflow);
    end
    checks++;
    if (digits_out[15:12] !== 4'd9) begin
      errors++;
      $display("FAIL ovf_store: got digit3=%0d, expected 9", digits_out[15:12]);
    end
    evt_ready = 1'b1;
    hold(3);
    checks++;
    if (evt_valid !== 1'b0 || evt_overflow !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL ovf_drain: got v=%b ovf=%b pending=%0d, expected 0/1/0", evt_valid, evt_overflow, exp_q.size());
    end
  endtask

  task automatic test_multi_select();
    int seen0;
    seen0 = evt_seen;
    drive(SEG_6, 4'b1100);
    hold(20);
    checks++;
    if (evt_seen != seen0 || evt_valid !== 1'b0 || digits_out[3:0] !== 4'd1) begin
      errors++;
      $display("FAIL multi_nocommit: got events=%0d v=%b digit0=%0d, expected 0/0/1",
               evt_seen - seen0, evt_valid, digits_out[3:0]);
    end
    drive(SEG_6, 4'b1110);
    expect_evt(3'd0, 4'd6, 1'b0);
    hold(4);
    checks++;
    if (digits_out[3:0] !== 4'd1) begin
      errors++;
      $display("FAIL multi_early: got digit0=%0d at E+3, expected 1", digits_out[3:0]);
    end
    tick();
    checks++;
    if (digits_out[3:0] !== 4'd6) begin
      errors++;
      $display("FAIL multi_commit: got digit0=%0d at E+4, expected 6", digits_out[3:0]);
    end
    hold(3);
  endtask

  task automatic test_no_change();
    int seen0;
    seen0 = evt_seen;
    drive(7'h00, 4'b1111);
    hold(3);
    drive(SEG_6, 4'b1110);
    hold(8);
    checks++;
    if (evt_seen != seen0 || evt_valid !== 1'b0 || digits_out[3:0] !== 4'd6) begin
      errors++;
      $display("FAIL recommit_event: got events=%0d v=%b digit0=%0d, expected 0/0/6",
               evt_seen - seen0, evt_valid, digits_out[3:0]);
    end
  endtask

  task automatic test_mid_reset();
    evt_ready = 1'b0;
    drive(SEG_2, 4'b1011);
    hold(6);
    checks++;
    if (evt_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_pending: got v=%b, expected 1", evt_valid);
    end
    drive(SEG_4, 4'b1101);
    hold(2);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    checks++;
    if (digits_out !== '0 || digit_valid !== '0 || bad_pattern !== '0) begin
      errors++;
      $display("FAIL rst_async_storage: got digits=%h valid=%b bad=%b, expected 0", digits_out, digit_valid, bad_pattern);
    end
    checks++;
    if ({evt_valid, evt_idx, evt_digit, evt_bad, evt_overflow} !== '0) begin
      errors++;
      $display("FAIL rst_async_event: got v=%b idx=%0d d=%0d b=%b ovf=%b, expected 0",
               evt_valid, evt_idx, evt_digit, evt_bad, evt_overflow);
    end
    tick();
    rst_n = 1'b1;
    evt_ready = 1'b1;
    expect_evt(3'd1, 4'd4, 1'b0);
    hold(4);
    checks++;
    if (digit_valid !== 4'b0000) begin
      errors++;
      $display("FAIL rst_requal_early: got valid=%b at E+3, expected 0000", digit_valid);
    end
    tick();
    checks++;
    if (digits_out[7:4] !== 4'd4 || digit_valid !== 4'b0010) begin
      errors++;
      $display("FAIL rst_requal_commit: got digit1=%0d valid=%b, expected 4/0010", digits_out[7:4], digit_valid);
    end
    hold(3);
    checks++;
    if (exp_q.size() != 0 || evt_overflow !== 1'b0) begin
      errors++;
      $display("FAIL rst_requal_event: got pending=%0d ovf=%b, expected 0/0", exp_q.size(), evt_overflow);
    end
  endtask

  initial begin
    rst_n = 1'b0; evt_ready = 1'b1;
    seg_n = '1; dig_en_n = '1;
    test_reset();
    test_stable();
    test_glitch();
    test_illegal();
    test_overflow();
    test_multi_select();
    test_no_change();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
